imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/sparc_pkg.sv | 13 +
 rtl/imem_array.sv | 28 ++
 rtl/imem_responder.sv | 114 +++++++++++
 tb/tb_imem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state encoding
// and the instruction word width.
package sparc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port for program load and one
// combinational read port sampled by the responder when it enters RESP.
module imem_array
  import sparc_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // No reset on the storage so a loaded program survives a responder reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed LATENCY.
// Define IMEM_ADDR_CHECK_EN to flag misaligned / out-of-range fetches via rsp_err.
module imem_responder
  import sparc_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORD_W-1:0]              rsp_data,
  output logic                           rsp_err,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [WORD_W-1:0]              prog_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     wordIdx_q, wordIdx_d;
  logic              addrErr_q, addrErr_d;
  logic [WORD_W-1:0] rspData_q, rspData_d;
  logic              rspErr_q, rspErr_d;
  logic [WORD_W-1:0] rdData;
  logic              reqAddrErr;

`ifdef IMEM_ADDR_CHECK_EN
  assign reqAddrErr = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  // Without checking, byte offset and upper bits are ignored and the index wraps.
  logic unusedAddrBits;
  assign reqAddrErr     = 1'b0;
  assign unusedAddrBits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (prog_we & reset),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (wordIdx_q),
    .rdata_o (rdData)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wordIdx_d = wordIdx_q;
    addrErr_d = addrErr_q;
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = WAIT;
          cnt_d     = 3'(LATENCY - 1);
          wordIdx_d = req_addr[AW+1:2];
          addrErr_d = reqAddrErr;
        end
      end
      WAIT: begin
        // The array is sampled on the same edge that enters RESP, so a
        // program write on that edge is not yet visible here.
        if (cnt_q == 3'd0) begin
          state_d   = RESP;
          rspData_d = addrErr_q ? '0 : rdData;
          rspErr_d  = addrErr_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wordIdx_q <= '0;
      addrErr_q <= 1'b0;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wordIdx_q <= wordIdx_d;
      addrErr_q <= addrErr_d;
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rspData_q;
  assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for the main checks
// and a LATENCY=3 instance for write-versus-read ordering during WAIT.
module tb_imem_responder;

`ifdef IMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reqAddr;
  logic        progWe;
  logic [5:0]  progAddr;
  logic [31:0] progData;

  logic        reqValid2, reqReady2, rspValid2, rspReady2, rspErr2;
  logic [31:0] rspData2;
  logic        reqValid3, reqReady3, rspValid3, rspReady3, rspErr3;
  logic [31:0] rspData3;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid2), .req_ready(reqReady2), .req_addr(reqAddr),
    .rsp_valid(rspValid2), .rsp_ready(rspReady2), .rsp_data(rspData2), .rsp_err(rspErr2),
    .prog_we(progWe), .prog_addr(progAddr), .prog_data(progData)
  );

  imem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid3), .req_ready(reqReady3), .req_addr(reqAddr),
    .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_data(rspData3), .rsp_err(rspErr3),
    .prog_we(progWe), .prog_addr(progAddr), .prog_data(progData)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic progWrite(input logic [5:0] a, input logic [31:0] d);
    progWe   = 1'b1;
    progAddr = a;
    progData = d;
    tick();
    progWe   = 1'b0;
  endtask

  // One full fetch on the LATENCY=2 instance; the address bus is scrambled
  // after accept to prove the request address was latched.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expData,
                               input logic expErr, input string name);
    int n;
    checkOutput({name, " ready"}, {31'd0, reqReady2}, 32'd1);
    reqAddr   = addr;
    reqValid2 = 1'b1;
    tick();
    reqValid2 = 1'b0;
    reqAddr   = ~addr;
    n = 0;
    while (!rspValid2 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({name, " latency"}, n, 32'd2);
    checkOutput({name, " data"}, rspData2, expData);
    checkOutput({name, " err"}, {31'd0, rspErr2}, {31'd0, expErr});
    rspReady2 = 1'b1;
    tick();
    rspReady2 = 1'b0;
    checkOutput({name, " ready after"}, {31'd0, reqReady2}, 32'd1);
    checkOutput({name, " valid after"}, {31'd0, rspValid2}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset     = 1'b0;
    reqAddr   = '0;
    progWe    = 1'b0;
    progAddr  = '0;
    progData  = '0;
    reqValid2 = 1'b0;
    rspReady2 = 1'b0;
    reqValid3 = 1'b0;
    rspReady3 = 1'b0;

    vecs[0] = '{32'h0000_000C, 32'h8200_0001, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vecs[2] = '{32'h0000_0014, 32'h1111_2222, 1'b0};
    vecs[3] = '{32'h0000_00FC, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{32'h0000_0004, 32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{32'h0000_010C, CHK ? 32'h0 : 32'h8200_0001, CHK};
    vecs[6] = '{32'h0000_000D, CHK ? 32'h0 : 32'h8200_0001, CHK};
    vecs[7] = '{32'h0000_0102, CHK ? 32'h0 : 32'h0000_0013, CHK};

    tick();
    tick();
    checkOutput("reset ready", {31'd0, reqReady2}, 32'd1);
    checkOutput("reset valid", {31'd0, rspValid2}, 32'd0);
    checkOutput("reset data", rspData2, 32'd0);
    checkOutput("reset err", {31'd0, rspErr2}, 32'd0);
    checkOutput("reset ready3", {31'd0, reqReady3}, 32'd1);
    reset = 1'b1;
    tick();

    progWrite(6'd0, 32'h0000_0013);
    progWrite(6'd1, 32'hA5A5_A5A5);
    progWrite(6'd3, 32'h8200_0001);
    progWrite(6'd5, 32'h1111_2222);
    progWrite(6'd63, 32'hCAFE_F00D);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].expData, vecs[i].expErr, $sformatf("vec%0d", i));
    end

    // Response held under back-pressure while stray requests are ignored.
    reqAddr   = 32'h0000_000C;
    reqValid2 = 1'b1;
    tick();
    reqValid2 = 1'b0;
    n = 0;
    while (!rspValid2 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("stall latency", n, 32'd2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall valid", {31'd0, rspValid2}, 32'd1);
      checkOutput("stall data", rspData2, 32'h8200_0001);
      checkOutput("stall ready", {31'd0, reqReady2}, 32'd0);
      reqAddr   = 32'h0000_0014;
      reqValid2 = i[0];
      tick();
    end
    reqValid2 = 1'b0;
    checkOutput("stall data end", rspData2, 32'h8200_0001);
    rspReady2 = 1'b1;
    tick();
    rspReady2 = 1'b0;
    checkOutput("stall release ready", {31'd0, reqReady2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall no ghost", {31'd0, rspValid2}, 32'd0);
    end

    // Reset during WAIT drops the fetch; the program write in that cycle is ignored.
    reqAddr   = 32'h0000_000C;
    reqValid2 = 1'b1;
    tick();
    reqValid2 = 1'b0;
    reset     = 1'b0;
    progWe    = 1'b1;
    progAddr  = 6'd3;
    progData  = 32'h0BAD_BAD0;
    tick();
    reset  = 1'b1;
    progWe = 1'b0;
    checkOutput("wait-rst ready", {31'd0, reqReady2}, 32'd1);
    checkOutput("wait-rst data", rspData2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wait-rst valid", {31'd0, rspValid2}, 32'd0);
      tick();
    end
    applyStimulus(32'h0000_000C, 32'h8200_0001, 1'b0, "idx3 kept");

    // Reset while a response is presented discards it.
    reqAddr   = 32'h0000_0014;
    reqValid2 = 1'b1;
    tick();
    reqValid2 = 1'b0;
    n = 0;
    while (!rspValid2 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("resp-rst pre valid", {31'd0, rspValid2}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("resp-rst data", rspData2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("resp-rst valid", {31'd0, rspValid2}, 32'd0);
      tick();
    end

    // LATENCY=3: write at edge k+1 is seen by the fetch.
    reqAddr   = 32'h0000_0014;
    reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    progWe    = 1'b1;
    progAddr  = 6'd5;
    progData  = 32'hDEAD_BEEF;
    tick();
    progWe = 1'b0;
    n = 1;
    while (!rspValid3 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("early write latency", n, 32'd3);
    checkOutput("early write data", rspData3, 32'hDEAD_BEEF);
    rspReady3 = 1'b1;
    tick();
    rspReady3 = 1'b0;

    // LATENCY=3: write at edge k+3 lands after the read sample.
    progWrite(6'd5, 32'h1111_2222);
    reqAddr   = 32'h0000_0014;
    reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    tick();
    tick();
    checkOutput("late write pre valid", {31'd0, rspValid3}, 32'd0);
    progWe   = 1'b1;
    progAddr = 6'd5;
    progData = 32'hDEAD_BEEF;
    tick();
    progWe = 1'b0;
    checkOutput("late write valid", {31'd0, rspValid3}, 32'd1);
    checkOutput("late write data", rspData3, 32'h1111_2222);
    rspReady3 = 1'b1;
    tick();
    rspReady3 = 1'b0;
    checkOutput("late write ready3", {31'd0, reqReady3}, 32'd1);
    applyStimulus(32'h0000_0014, 32'hDEAD_BEEF, 1'b0, "late write landed");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
